// File: rtl/mem_arbiter_pkg.sv
// Shared encodings and widths for the CPU/DMA memory arbiter.
// Sequencer states, bus owner, and the wait/burst counter widths.
package mem_arbiter_pkg;

   localparam int WAIT_W  = 8;
   localparam int BURST_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_TURN   = 2'd3
   } state_e;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_e;

   function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] v);
      return (v == '1) ? v : v + WAIT_W'(1);
   endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational owner selection between the CPU and DMA requesters.
// CPU is preferred unless DMA is starved or is mid-burst under its burst limit.
module mem_arb_pick
   import mem_arbiter_pkg::*;
#(
   parameter int STARVE_LIM = 8,
   parameter int BURST_MAX  = 4
) (
   input  logic               cpu_req,
   input  logic               dma_req,
   input  logic [WAIT_W-1:0]  wait_cnt,
   input  logic [BURST_W-1:0] burst_cnt,
   input  logic               dma_cont,
   output owner_e             pick
);

   // A burst at its limit hands the bus back to the CPU ahead of any starvation claim.
   always_comb begin
      pick = OWN_CPU;
      if (cpu_req && dma_req) begin
         if (burst_cnt >= BURST_W'(BURST_MAX)) begin
            pick = OWN_CPU;
         end else if (dma_cont || (wait_cnt >= WAIT_W'(STARVE_LIM))) begin
            pick = OWN_DMA;
         end
      end else if (dma_req) begin
         pick = OWN_DMA;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (CPU, DMA) arbiter driving an async SRAM-style bus with
// registered active-low strobes; one SETUP and one STROBE cycle per access.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | no access; bus parked (addr 0, strobes high)
//   ST_SETUP  | granted address on bus, strobes high
//   ST_STROBE | oe or we low for the granted direction
//   ST_TURN   | one dead cycle when ownership changes between requesters
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int STARVE_LIM = 8,
   parameter int BURST_MAX  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              cpu_wr,
   output logic              cpu_stall,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic              dma_wr,
   output logic              dma_done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_oe,
   output logic              mem_we
);

   state_e             state, state_d;
   owner_e             owner, pend, pick, grant_own;
   logic               grant;
   logic               acc_wr;
   logic               pend_req;
   logic               dma_cont;
   logic               dma_owns;
   logic [ADDR_W-1:0]  grant_addr;
   logic               grant_wr;
   logic [WAIT_W-1:0]  wait_cnt;
   logic [BURST_W-1:0] burst_cnt;

   assign dma_cont   = (state == ST_STROBE) && (owner == OWN_DMA);
   assign dma_owns   = (state != ST_IDLE) && (owner == OWN_DMA);
   assign pend_req   = (pend == OWN_DMA) ? dma_req : cpu_req;
   assign grant_addr = (grant_own == OWN_DMA) ? dma_addr : cpu_addr;
   assign grant_wr   = (grant_own == OWN_DMA) ? dma_wr : cpu_wr;
   assign cpu_stall  = cpu_req && !((state == ST_STROBE) && (owner == OWN_CPU));

   mem_arb_pick #(
      .STARVE_LIM (STARVE_LIM),
      .BURST_MAX  (BURST_MAX)
   ) u_pick (
      .cpu_req   (cpu_req),
      .dma_req   (dma_req),
      .wait_cnt  (wait_cnt),
      .burst_cnt (burst_cnt),
      .dma_cont  (dma_cont),
      .pick      (pick)
   );

   // A request level seen in STROBE is taken as the owner's next access.
   always_comb begin
      state_d   = state;
      grant     = 1'b0;
      grant_own = pick;
      case (state)
         ST_IDLE: begin
            if (cpu_req || dma_req) begin
               grant   = 1'b1;
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: state_d = ST_STROBE;
         ST_STROBE: begin
            if (!(cpu_req || dma_req)) begin
               state_d = ST_IDLE;
            end else if (pick != owner) begin
               state_d = ST_TURN;
            end else begin
               grant   = 1'b1;
               state_d = ST_SETUP;
            end
         end
         ST_TURN: begin
            if (pend_req) begin
               grant     = 1'b1;
               grant_own = pend;
               state_d   = ST_SETUP;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state     <= ST_IDLE;
         owner     <= OWN_CPU;
         pend      <= OWN_CPU;
         acc_wr    <= 1'b0;
         mem_addr  <= '0;
         wait_cnt  <= '0;
         burst_cnt <= '0;
         mem_oe    <= 1'b1;
         mem_we    <= 1'b1;
         dma_done  <= 1'b0;
      end else begin
         state <= state_d;
         if (grant) begin
            owner    <= grant_own;
            acc_wr   <= grant_wr;
            mem_addr <= grant_addr;
         end else if (state_d == ST_IDLE) begin
            mem_addr <= '0;
         end
         if ((state == ST_STROBE) && (state_d == ST_TURN)) begin
            pend <= pick;
         end
         if (grant && (grant_own == OWN_DMA)) begin
            wait_cnt <= '0;
         end else if (dma_req && !dma_owns) begin
            wait_cnt <= wait_sat_inc(wait_cnt);
         end
         if (grant && (grant_own == OWN_CPU)) begin
            burst_cnt <= '0;
         end else if (grant) begin
            burst_cnt <= (burst_cnt == '1) ? burst_cnt : burst_cnt + BURST_W'(1);
         end
         // SETUP is always followed by STROBE, so strobes are decoded one cycle early.
         mem_oe   <= !((state == ST_SETUP) && !acc_wr);
         mem_we   <= !((state == ST_SETUP) && acc_wr);
         dma_done <= (state == ST_STROBE) && (owner == OWN_DMA);
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 16, address width.
REQ-002 SHALL have parameter STARVE_LIM, 8, DMA wait cycles before DMA overrides CPU priority (1..255).
REQ-003 SHALL have parameter BURST_MAX, 4, consecutive DMA accesses before CPU regains priority (1..15).
REQ-004 clk  in  1  single clock; all state updates on posedge clk.
REQ-005 rst  in  1  synchronous, active-low reset.
REQ-006 cpu_req  in  1  CPU requests one memory access.
REQ-007 cpu_addr  in  ADDR_W  CPU address.
REQ-008 cpu_wr  in  1  1 = write, 0 = read.
REQ-009 cpu_stall  out  1  1 = CPU must hold its request and state.
REQ-010 dma_req  in  1  DMA requests one memory access.
REQ-011 dma_addr  in  ADDR_W  DMA address.
REQ-012 dma_wr  in  1  1 = write, 0 = read.
REQ-013 dma_done  out  1  one-cycle pulse; DMA access completed.
REQ-014 mem_addr  out  ADDR_W  external address bus.
REQ-015 mem_oe  out  1  active-low memory output enable.
REQ-016 mem_we  out  1  active-low memory write enable.

Function
REQ-017 FSM states SHALL be IDLE, SETUP, STROBE, TURN.
REQ-018 IDLE: owner chosen when any request is high -> SETUP; otherwise stay; mem_oe = mem_we = 1, mem_addr = 0.
REQ-019 Owner choice SHALL be CPU when cpu_req, unless dma_req and (wait_cnt >= STARVE_LIM); DMA when only dma_req.
REQ-020 SETUP (1 cycle): mem_addr = owner address, latched at owner choice; both strobes high; -> STROBE.
REQ-021 STROBE (1 cycle): mem_oe = 0 if read, mem_we = 0 if write, never both low; mem_addr held; -> TURN if next owner differs from current, else SETUP when a request is pending, else IDLE.
REQ-022 TURN (1 cycle): both strobes high, mem_addr held; -> SETUP with the pending owner, or IDLE.
REQ-023 The cycle in which a CPU access is in STROBE SHALL be the only cycle with cpu_stall = 0 while cpu_req = 1; cpu_stall = 0 whenever cpu_req = 0.
REQ-024 dma_done SHALL pulse 1 in the cycle following DMA STROBE.
REQ-025 wait_cnt (8-bit, saturating at 255) SHALL increment each cycle dma_req = 1 and DMA is not owner; clear on DMA grant.
REQ-026 burst_cnt (4-bit) SHALL increment per DMA access, clear on CPU grant; when burst_cnt = BURST_MAX and cpu_req = 1, the next grant SHALL go to CPU regardless of wait_cnt.
REQ-027 Address and direction SHALL be captured at grant; requester changes mid-access SHALL be ignored.
REQ-028 Requests dropped before grant SHALL be forgotten; requests dropped mid-access SHALL not abort it.
REQ-029 Simultaneous cpu_req and dma_req with counters at 0: CPU SHALL win.
REQ-030 Back-to-back same-owner accesses SHALL take 2 cycles each; owner change SHALL add 1 TURN cycle.

Reset
REQ-031 With rst = 0 at posedge clk: state = IDLE, wait_cnt = 0, burst_cnt = 0, mem_oe = 1, mem_we = 1, mem_addr = 0, dma_done = 0, cpu_stall = cpu_req.
REQ-032 Reset during SETUP/STROBE/TURN SHALL abort the access in that cycle; strobes high next cycle.

Structure
REQ-033 State encoding and owner enum SHALL live in the shared CPU package with other control constants.
REQ-034 Grant selection (REQ-019, REQ-026) SHALL be one combinational sub-module, mem_arb_pick; FSM and counters in mem_arbiter.
REQ-035 Strobe outputs SHALL be registered, glitch-free.

Verification
REQ-036 CPU-only read at 0x1234 -> SETUP, mem_oe = 0 for 1 cycle with mem_addr = 0x1234, cpu_stall released in STROBE, mem_we = 1 throughout.
REQ-037 cpu_req and dma_req asserted same cycle, counters 0 -> CPU access first, TURN, then DMA; dma_done 5 cycles after start.
REQ-038 cpu_req held continuously, dma_req held, STARVE_LIM = 8 -> DMA granted once wait_cnt reaches 8; no cycle with both strobes low.
REQ-039 DMA writes continuous, cpu_req raised, BURST_MAX = 4 -> exactly 4 DMA accesses then TURN, CPU access.
REQ-040 rst = 0 during DMA STROBE (write) -> next cycle mem_we = 1, state IDLE, no dma_done pulse.
REQ-041 dma_addr changed during DMA SETUP -> mem_addr keeps granted value through STROBE.
